// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and helpers for the instruction fetch memory
package instr_mem_pkg;

  // Bit 1 = out of range, bit 0 = misaligned, matching the rsp_fault port layout
  typedef struct packed {
    logic out_of_range;
    logic misaligned;
  } fault_t;

  typedef enum logic {
    ENDIAN_BIG    = 1'b0,
    ENDIAN_LITTLE = 1'b1
  } endian_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          FAULT_W   = $bits(fault_t);

  // b0 is the byte at the lowest address of the word
  function automatic logic [31:0] assemble_word(input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3,
                                                input endian_e order);
    return (order == ENDIAN_LITTLE) ? {b3, b2, b1, b0} : {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/instr_rsp_fifo.sv
// rtl/instr_rsp_fifo.sv - two-entry response FIFO between the read stage and decode
module instr_rsp_fifo #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   cnt,
  output logic         empty
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  fifo_state_e  state;
  logic [W-1:0] entry0;
  logic [W-1:0] entry1;

  // Occupancy FSM; entry0 is always the head, so a pop shifts entry1 forward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            entry0 <= push_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            entry0 <= push_data;
          end else if (push) begin
            entry1 <= push_data;
            state  <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            entry0 <= entry1;
            if (push) entry1 <= push_data;
            else      state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign head_data = entry0;
  assign cnt       = state;
  assign empty     = (state == EMPTY);

endmodule

// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - byte-addressable instruction memory with registered read and valid/ready fetch
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int          ADDR_W        = 32,
  parameter int          DEPTH_BYTES   = 4096,
  parameter int          LITTLE_ENDIAN = 1,
  parameter string       INIT_FILE     = "program.mem",
  parameter logic [31:0] FILL_WORD     = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault
);

  localparam int                IDX_W     = $clog2(DEPTH_BYTES);
  localparam int                ENT_W     = 32 + ADDR_W + FAULT_W;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);
  localparam endian_e           ORDER     = (LITTLE_ENDIAN != 0) ? ENDIAN_LITTLE : ENDIAN_BIG;

  logic [7:0] mem [DEPTH_BYTES];

  fault_t            req_fault;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word;

  logic              s1_valid;
  logic [31:0]       s1_instr;
  logic [ADDR_W-1:0] s1_addr;
  fault_t            s1_fault;

  logic [ENT_W-1:0]  s1_entry;
  logic [ENT_W-1:0]  fifo_head;
  logic [ENT_W-1:0]  head;
  logic [1:0]        fifo_cnt;
  logic              fifo_empty;
  logic [2:0]        outstanding;
  logic              accept;
  logic              pop;
  logic              fifo_push;
  logic              fifo_pop;

  // Fault decode and byte gather; faulting fetches never touch the array
  always_comb begin
    req_fault.misaligned   = (req_addr[1:0] != 2'b00);
    req_fault.out_of_range = (req_addr > LAST_WORD);
    idx     = req_addr[IDX_W-1:0];
    rd_word = FILL_WORD;
    if (!req_fault.misaligned && !req_fault.out_of_range) begin
      rd_word = assemble_word(mem[idx], mem[idx + IDX_W'(1)],
                              mem[idx + IDX_W'(2)], mem[idx + IDX_W'(3)], ORDER);
    end
  end

  // S1 and the FIFO together never hold more than two responses, so S1 always drains next edge
  assign outstanding = {1'b0, fifo_cnt} + {2'b00, s1_valid};
  assign rsp_valid   = s1_valid | !fifo_empty;
  assign req_ready   = flush | (outstanding < 3'd2) | (rsp_valid & rsp_ready);
  assign accept      = req_valid & req_ready;
  assign pop         = rsp_valid & rsp_ready & !flush;
  assign fifo_pop    = pop & !fifo_empty;
  assign fifo_push   = s1_valid & !(fifo_empty & pop);

  // Registered read stage; a flush keeps only the request presented alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_addr  <= '0;
      s1_fault <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_instr <= rd_word;
        s1_addr  <= req_addr;
        s1_fault <= req_fault;
      end
    end
  end

  assign s1_entry = {s1_instr, s1_addr, s1_fault};

  instr_rsp_fifo #(
    .W (ENT_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (s1_entry),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .cnt       (fifo_cnt),
    .empty     (fifo_empty)
  );

  // With the FIFO empty, S1 is presented directly so a fetch is visible the cycle after acceptance
  assign head = fifo_empty ? s1_entry : fifo_head;
  assign {rsp_instr, rsp_addr, rsp_fault} = head;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - directed table-driven bench for instr_fetch_mem
module tb_instr_fetch_mem;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] FILL   = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              rsp_ready = 1'b0;

  logic              req_ready_le, rsp_valid_le;
  logic [31:0]       rsp_instr_le;
  logic [ADDR_W-1:0] rsp_addr_le;
  logic [1:0]        rsp_fault_le;

  logic              req_ready_be, rsp_valid_be;
  logic [31:0]       rsp_instr_be;
  logic [ADDR_W-1:0] rsp_addr_be;
  logic [1:0]        rsp_fault_be;

  int checks = 0;
  int failures = 0;

  instr_fetch_mem #(
    .ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .LITTLE_ENDIAN(1), .INIT_FILE(""), .FILL_WORD(FILL)
  ) dut_le (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready_le),
    .req_addr(req_addr), .rsp_valid(rsp_valid_le), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_le), .rsp_addr(rsp_addr_le), .rsp_fault(rsp_fault_le)
  );

  instr_fetch_mem #(
    .ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .LITTLE_ENDIAN(0), .INIT_FILE(""), .FILL_WORD(FILL)
  ) dut_be (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready_be),
    .req_addr(req_addr), .rsp_valid(rsp_valid_be), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_be), .rsp_addr(rsp_addr_be), .rsp_fault(rsp_fault_be)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        rr;
    logic        x_ready;
    logic        x_valid;
    logic [31:0] x_instr;
    logic [31:0] x_addr;
    logic [1:0]  x_fault;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 after the rising edge; outputs are sampled 3 after it
  task automatic drive(input logic rv, input logic [31:0] a, input logic rr, input logic fl);
    @(posedge clk);
    #1;
    req_valid = rv;
    req_addr  = a;
    rsp_ready = rr;
    flush     = fl;
    #2;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                           input logic [1:0] fault);
    check({tag, "_valid"}, 32'(rsp_valid_le), 32'd1);
    check({tag, "_instr"}, rsp_instr_le, instr);
    check({tag, "_addr"}, rsp_addr_le, addr);
    check({tag, "_fault"}, 32'(rsp_fault_le), 32'(fault));
  endtask

  initial begin
    //          rv    addr          rr    rdy   vld   instr          addr          fault
    vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,        2'b00};
    vecs[1]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b1, 32'h0302_0100, 32'h0,        2'b00};
    vecs[2]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b1, 32'h0706_0504, 32'h4,        2'b00};
    vecs[3]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 32'h0B0A_0908, 32'h8,        2'b00};
    vecs[4]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0F0E_0D0C, 32'hC,        2'b00};
    vecs[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,        2'b00};
    vecs[6]  = '{1'b1, 32'h0000_0002, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,        2'b00};
    vecs[7]  = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1, FILL,          32'h2,        2'b01};
    vecs[8]  = '{1'b1, 32'h0000_0101, 1'b1, 1'b1, 1'b1, FILL,          32'h100,      2'b10};
    vecs[9]  = '{1'b1, 32'h0000_00FC, 1'b1, 1'b1, 1'b1, FILL,          32'h101,      2'b11};
    vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'hFFFE_FDFC, 32'hFC,       2'b00};
    vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,        2'b00};
    vecs[12] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0,        2'b00};
    vecs[13] = '{1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 32'h0302_0100, 32'h0,        2'b00};
    vecs[14] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0302_0100, 32'h0,        2'b00};
    vecs[15] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0302_0100, 32'h0,        2'b00};
    vecs[16] = '{1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 32'h0302_0100, 32'h0,        2'b00};
    vecs[17] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b1, 32'h0302_0100, 32'h0,        2'b00};
    vecs[18] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0706_0504, 32'h4,        2'b00};
    vecs[19] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0B0A_0908, 32'h8,        2'b00};
    vecs[20] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,        2'b00};

    for (int i = 0; i < DEPTH; i++) begin
      dut_le.mem[i] = 8'(i);
      dut_be.mem[i] = 8'(i);
    end

    @(posedge clk);
    #3;
    check("reset_valid", 32'(rsp_valid_le), 32'd0);
    check("reset_instr", rsp_instr_le, 32'h0);
    check("reset_addr", rsp_addr_le, 32'h0);
    check("reset_fault", 32'(rsp_fault_le), 32'h0);
    check("reset_ready", 32'(req_ready_le), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rv, vecs[i].addr, vecs[i].rr, 1'b0);
      check($sformatf("v%0d_ready", i), 32'(req_ready_le), 32'(vecs[i].x_ready));
      check($sformatf("v%0d_valid", i), 32'(rsp_valid_le), 32'(vecs[i].x_valid));
      if (vecs[i].x_valid) begin
        check($sformatf("v%0d_instr", i), rsp_instr_le, vecs[i].x_instr);
        check($sformatf("v%0d_addr", i), rsp_addr_le, vecs[i].x_addr);
        check($sformatf("v%0d_fault", i), 32'(rsp_fault_le), 32'(vecs[i].x_fault));
      end
    end

    // Big-endian byte order on the second instance
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    check("be_req_ready", 32'(req_ready_be), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("be_valid", 32'(rsp_valid_be), 32'd1);
    check("be_instr", rsp_instr_be, 32'h0405_0607);
    check("be_addr", rsp_addr_be, 32'h4);
    check("be_fault", 32'(rsp_fault_be), 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("be_drained", 32'(rsp_valid_be), 32'd0);

    // Flush with one buffered and one in S1; a pop in the flush cycle is ignored
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 1'b1);
    check("flush1_ready", 32'(req_ready_le), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_rsp("flush1_target", 32'h0B0A_0908, 32'h8, 2'b00);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check_rsp("flush1_hold", 32'h0B0A_0908, 32'h8, 2'b00);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush1_empty", 32'(rsp_valid_le), 32'd0);

    // Flush with two responses buffered and the FIFO full
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("full_ready", 32'(req_ready_le), 32'd0);
    drive(1'b1, 32'hC, 1'b1, 1'b1);
    check("flush2_ready", 32'(req_ready_le), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check_rsp("flush2_target", 32'h0F0E_0D0C, 32'hC, 2'b00);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush2_empty", 32'(rsp_valid_le), 32'd0);

    // Reset asserted mid-stream drops everything immediately
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(rsp_valid_le), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid_le), 32'd0);
    check("mid_rst_instr", rsp_instr_le, 32'h0);
    check("mid_rst_addr", rsp_addr_le, 32'h0);
    check("mid_rst_fault", 32'(rsp_fault_le), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_rst_valid", 32'(rsp_valid_le), 32'd0);
    check("post_rst_ready", 32'(req_ready_le), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
